// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the single-cycle execution controller.
package exec_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_MAN = 3'd1,
    ST_LOAD_MEM = 3'd2,
    ST_EXEC     = 3'd3,
    ST_HALT     = 3'd4
  } state_e;

  localparam logic [3:0] HALT_OPC_DEFAULT = 4'hF;

  // Opcode field position inside a 16-bit instruction word
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous reset, hold, wrapping increment and branch load.
module pc_counter #(
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Branch load wins over increment; increment wraps naturally at 2^PC_W
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/exec_controller.sv
// Load/execute sequencer for a Basys-board processor: manual, single-step and
// free-run instruction issue with halt detection on the fetched opcode.
module exec_controller
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter logic [3:0]  HALT_OPC = HALT_OPC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            manual_req,
  input  logic            step_req,
  input  logic            run_req,
  input  logic            stop_req,
  input  logic [15:0]     imem_data,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            sel_basys,
  output logic            sel_mem,
  output logic            exec_en,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [2:0]      state_dbg
);

  state_e state_q, state_d;
  logic   run_mode_q, run_mode_d;
  logic   stop_pending_q, stop_pending_d;
  logic   from_mem_q, from_mem_d;
  logic   pc_inc;
  logic   pc_load;
  logic   is_halt_c;
  logic   imem_unused;

  assign is_halt_c   = (imem_data[OPC_MSB:OPC_LSB] == HALT_OPC);
  assign imem_unused = ^imem_data[OPC_LSB-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      run_mode_q     <= 1'b0;
      stop_pending_q <= 1'b0;
      from_mem_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_mode_q     <= run_mode_d;
      stop_pending_q <= stop_pending_d;
      from_mem_q     <= from_mem_d;
    end
  end

  // Next state and strobes; only sel_mem looks at the live opcode
  always_comb begin
    state_d        = state_q;
    run_mode_d     = run_mode_q;
    stop_pending_d = stop_pending_q;
    from_mem_d     = from_mem_q;
    sel_basys      = 1'b0;
    sel_mem        = 1'b0;
    exec_en        = 1'b0;
    halted         = 1'b0;
    pc_inc         = 1'b0;
    pc_load        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stop_req) begin
          run_mode_d = 1'b0;
        end else if (manual_req) begin
          state_d    = ST_LOAD_MAN;
          from_mem_d = 1'b0;
        end else if (step_req) begin
          state_d    = ST_LOAD_MEM;
          from_mem_d = 1'b1;
          run_mode_d = 1'b0;
        end else if (run_req) begin
          state_d    = ST_LOAD_MEM;
          from_mem_d = 1'b1;
          run_mode_d = 1'b1;
        end
      end
      ST_LOAD_MAN: begin
        sel_basys = 1'b1;
        state_d   = ST_EXEC;
      end
      ST_LOAD_MEM: begin
        if (stop_req) begin
          stop_pending_d = 1'b1;
        end
        if (is_halt_c) begin
          state_d = ST_HALT;
        end else begin
          sel_mem = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        exec_en = 1'b1;
        if (from_mem_q) begin
          pc_load = branch_taken;
          pc_inc  = ~branch_taken;
        end
        // A stop arriving in this very cycle still ends the run
        if (run_mode_q && !stop_pending_q && !stop_req) begin
          state_d = ST_LOAD_MEM;
        end else begin
          state_d        = ST_IDLE;
          run_mode_d     = 1'b0;
          stop_pending_d = 1'b0;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  pc_counter #(
    .PC_W(PC_W)
  ) u_pc_counter (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (pc_inc),
    .load_i  (pc_load),
    .target_i(branch_target),
    .pc_o    (pc)
  );

  assign state_dbg = state_q;

endmodule

// File: tb/tb_exec_controller.sv
// Self-checking bench for exec_controller: directed scenarios plus randomized
// request traffic compared against a transaction-level reference model.
module tb_exec_controller;
  import exec_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        manual_req, step_req, run_req, stop_req;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [15:0] imem_data;
  logic        sel_basys, sel_mem, exec_en, halted;
  logic [7:0]  pc;
  logic [2:0]  state_dbg;
  logic [3:0]  outs;
  logic [15:0] mem [256];
  int          total;
  int          bad;

  exec_controller dut (
    .clk          (clk),
    .reset        (reset),
    .manual_req   (manual_req),
    .step_req     (step_req),
    .run_req      (run_req),
    .stop_req     (stop_req),
    .imem_data    (imem_data),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .sel_basys    (sel_basys),
    .sel_mem      (sel_mem),
    .exec_en      (exec_en),
    .pc           (pc),
    .halted       (halted),
    .state_dbg    (state_dbg)
  );

  assign imem_data = mem[pc];
  assign outs      = {sel_basys, sel_mem, exec_en, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, cross the edge, then release all pulses
  task automatic tick(input logic rst, input logic m, input logic s, input logic r,
                      input logic p, input logic bt, input logic [7:0] tgt);
    reset = rst; manual_req = m; step_req = s; run_req = r; stop_req = p;
    branch_taken = bt; branch_target = tgt;
    @(posedge clk);
    #1;
    reset = 1'b0; manual_req = 1'b0; step_req = 1'b0; run_req = 1'b0; stop_req = 1'b0;
    branch_taken = 1'b0; branch_target = 8'h00;
  endtask

  task automatic fill_mem(input logic [15:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  task automatic test_reset;
    fill_mem(16'h1000);
    tick(1, 0, 0, 0, 0, 0, 8'h00);
    total++; if (outs !== 4'b0000) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs, 4'b0000); end
    total++; if (state_dbg !== 3'(ST_IDLE)) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, 3'(ST_IDLE)); end
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h exp=00", pc); end
  endtask

  task automatic test_manual;
    tick(0, 1, 0, 0, 0, 0, 8'h00);
    total++; if (outs !== 4'b1000) begin bad++; $display("FAIL manual_load got=%b exp=1000", outs); end
    tick(0, 0, 0, 0, 0, 1, 8'h77);
    total++; if (outs !== 4'b0010) begin bad++; $display("FAIL manual_exec got=%b exp=0010", outs); end
    tick(0, 0, 0, 0, 0, 0, 8'h00);
    total++; if (state_dbg !== 3'(ST_IDLE) || outs !== 4'b0000) begin bad++; $display("FAIL manual_idle state=%0d outs=%b exp state=0 outs=0000", state_dbg, outs); end
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL manual_pc got=%h exp=00", pc); end
  endtask

  task automatic test_step;
    tick(0, 0, 1, 0, 0, 0, 8'h00);
    tick(0, 0, 0, 0, 0, 0, 8'h00);
    tick(0, 0, 0, 0, 0, 1, 8'h05);
    total++; if (pc !== 8'h05) begin bad++; $display("FAIL step_branch_pc got=%h exp=05", pc); end
    mem[5] = 16'h1234;
    tick(0, 0, 1, 0, 0, 0, 8'h00);
    total++; if (outs !== 4'b0100) begin bad++; $display("FAIL step_load got=%b exp=0100", outs); end
    tick(0, 0, 0, 0, 0, 0, 8'h00);
    total++; if (outs !== 4'b0010) begin bad++; $display("FAIL step_exec got=%b exp=0010", outs); end
    tick(0, 0, 0, 0, 0, 0, 8'h00);
    total++; if (pc !== 8'h06 || state_dbg !== 3'(ST_IDLE)) begin bad++; $display("FAIL step_after pc=%h state=%0d exp pc=06 state=0", pc, state_dbg); end
  endtask

  task automatic test_ignored;
    tick(0, 1, 0, 0, 0, 0, 8'h00);
    tick(0, 0, 1, 0, 0, 0, 8'h00);
    tick(0, 0, 0, 1, 0, 0, 8'h00);
    total++; if (state_dbg !== 3'(ST_IDLE)) begin bad++; $display("FAIL ignored_busy state=%0d exp=0", state_dbg); end
    tick(0, 0, 0, 0, 0, 0, 8'h00);
    total++; if (state_dbg !== 3'(ST_IDLE) || outs !== 4'b0000) begin bad++; $display("FAIL not_queued state=%0d outs=%b exp state=0 outs=0000", state_dbg, outs); end
  endtask

  task automatic test_run_halt;
    logic [8:1] ex;
    tick(1, 0, 0, 0, 0, 0, 8'h00);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'hF000;
    tick(0, 0, 0, 1, 0, 0, 8'h00);
    ex[1] = exec_en;
    total++; if (sel_mem !== 1'b1) begin bad++; $display("FAIL run_first_load got=%b exp=1", sel_mem); end
    for (int c = 2; c <= 8; c++) begin
      tick(0, 0, 0, 0, 0, 0, 8'h00);
      ex[c] = exec_en;
      if (c == 7) begin
        total++; if (pc !== 8'h03 || sel_mem !== 1'b0 || state_dbg !== 3'(ST_LOAD_MEM)) begin bad++; $display("FAIL run_halt_fetch pc=%h sel_mem=%b state=%0d exp pc=03 sel_mem=0 state=2", pc, sel_mem, state_dbg); end
      end
    end
    total++; if (ex !== 8'b0010_1010) begin bad++; $display("FAIL run_exec_cycles got=%b exp=00101010", ex); end
    total++; if (outs !== 4'b0001 || state_dbg !== 3'(ST_HALT)) begin bad++; $display("FAIL run_halted outs=%b state=%0d exp outs=0001 state=4", outs, state_dbg); end
    for (int k = 0; k < 3; k++) tick(0, 1, 1, 1, 0, 0, 8'h00);
    total++; if (outs !== 4'b0001 || pc !== 8'h03) begin bad++; $display("FAIL halt_hold outs=%b pc=%h exp outs=0001 pc=03", outs, pc); end
    tick(1, 0, 0, 0, 0, 0, 8'h00);
    total++; if (halted !== 1'b0 || state_dbg !== 3'(ST_IDLE)) begin bad++; $display("FAIL halt_reset halted=%b state=%0d exp halted=0 state=0", halted, state_dbg); end
    fill_mem(16'h1000);
  endtask

  task automatic test_wrap_branch_stop;
    tick(0, 0, 1, 0, 0, 0, 8'h00);
    tick(0, 0, 0, 0, 0, 0, 8'h00);
    tick(0, 0, 0, 0, 0, 1, 8'hFF);
    tick(0, 0, 0, 1, 0, 0, 8'h00);
    tick(0, 0, 0, 0, 0, 0, 8'h00);
    total++; if (exec_en !== 1'b1 || pc !== 8'hFF) begin bad++; $display("FAIL wrap_exec exec=%b pc=%h exp exec=1 pc=ff", exec_en, pc); end
    tick(0, 0, 0, 0, 1, 0, 8'h00);
    total++; if (pc !== 8'h00 || state_dbg !== 3'(ST_IDLE)) begin bad++; $display("FAIL wrap_stop pc=%h state=%0d exp pc=00 state=0", pc, state_dbg); end
    tick(0, 0, 0, 1, 0, 0, 8'h00);
    tick(0, 0, 0, 0, 0, 0, 8'h00);
    tick(0, 0, 0, 0, 0, 1, 8'h10);
    total++; if (pc !== 8'h10 || outs !== 4'b0100) begin bad++; $display("FAIL run_branch pc=%h outs=%b exp pc=10 outs=0100", pc, outs); end
    tick(0, 0, 0, 0, 1, 0, 8'h00);
    total++; if (exec_en !== 1'b1) begin bad++; $display("FAIL pending_stop_commit got=%b exp=1", exec_en); end
    tick(0, 0, 0, 0, 0, 0, 8'h00);
    total++; if (pc !== 8'h11 || state_dbg !== 3'(ST_IDLE)) begin bad++; $display("FAIL pending_stop_idle pc=%h state=%0d exp pc=11 state=0", pc, state_dbg); end
  endtask

  task automatic test_stop_in_idle;
    tick(0, 0, 0, 1, 1, 0, 8'h00);
    total++; if (state_dbg !== 3'(ST_IDLE) || sel_mem !== 1'b0) begin bad++; $display("FAIL stop_run_idle state=%0d sel_mem=%b exp state=0 sel_mem=0", state_dbg, sel_mem); end
    tick(0, 0, 0, 0, 0, 0, 8'h00);
    total++; if (outs !== 4'b0000) begin bad++; $display("FAIL stop_run_quiet got=%b exp=0000", outs); end
  endtask

  task automatic test_reset_exec;
    tick(0, 0, 1, 0, 0, 0, 8'h00);
    tick(0, 0, 0, 0, 0, 0, 8'h00);
    tick(1, 0, 0, 0, 0, 1, 8'h42);
    total++; if (outs !== 4'b0000 || state_dbg !== 3'(ST_IDLE) || pc !== 8'h00) begin bad++; $display("FAIL reset_in_exec outs=%b state=%0d pc=%h exp outs=0000 state=0 pc=00", outs, state_dbg, pc); end
    mem[0] = 16'hF123;
    tick(0, 0, 1, 0, 0, 0, 8'h00);
    total++; if (sel_mem !== 1'b0 || state_dbg !== 3'(ST_LOAD_MEM)) begin bad++; $display("FAIL halt_suppress sel_mem=%b state=%0d exp sel_mem=0 state=2", sel_mem, state_dbg); end
    tick(0, 0, 0, 0, 0, 0, 8'h00);
    total++; if (outs !== 4'b0001) begin bad++; $display("FAIL halt_enter got=%b exp=0001", outs); end
    tick(1, 0, 0, 0, 0, 0, 8'h00);
    total++; if (halted !== 1'b0 || state_dbg !== 3'(ST_IDLE)) begin bad++; $display("FAIL reset_in_halt halted=%b state=%0d exp halted=0 state=0", halted, state_dbg); end
    mem[0] = 16'h1000;
  endtask

  // Model works in terms of instruction phases: idle, fetch (manual/memory), commit, halted
  task automatic test_random;
    int m_ph, m_pc;
    bit m_run, m_stop, m_src;
    logic rst, m, s, r, p, bt;
    logic [7:0] tgt;
    logic [15:0] w;
    logic [3:0] e_outs;
    logic [2:0] e_state;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF && $urandom_range(0, 3) != 0) w[15:12] = 4'h2;
      mem[i] = w;
    end
    m_ph = 0; m_pc = 0; m_run = 0; m_stop = 0; m_src = 0;
    for (int n = 0; n < 800; n++) begin
      rst = (n == 0) || ($urandom_range(0, 79) == 0);
      m = ($urandom_range(0, 7) == 0); s = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 5) == 0); p = ($urandom_range(0, 11) == 0);
      bt = ($urandom_range(0, 3) == 0); tgt = 8'($urandom);
      reset = rst; manual_req = m; step_req = s; run_req = r; stop_req = p;
      branch_taken = bt; branch_target = tgt;
      #1;
      if (n > 0) begin
        e_outs  = {m_ph == 1, m_ph == 2 && mem[m_pc][15:12] != 4'hF, m_ph == 3, m_ph == 4};
        e_state = (m_ph == 0) ? 3'(ST_IDLE) : (m_ph == 1) ? 3'(ST_LOAD_MAN) :
                  (m_ph == 2) ? 3'(ST_LOAD_MEM) : (m_ph == 3) ? 3'(ST_EXEC) : 3'(ST_HALT);
        total++; if (outs !== e_outs) begin bad++; $display("FAIL rnd_outs n=%0d got=%b exp=%b", n, outs, e_outs); end
        total++; if (state_dbg !== e_state) begin bad++; $display("FAIL rnd_state n=%0d got=%0d exp=%0d", n, state_dbg, e_state); end
        total++; if (pc !== 8'(m_pc)) begin bad++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, pc, 8'(m_pc)); end
        total++; if ($countones({sel_basys, sel_mem, exec_en}) > 1) begin bad++; $display("FAIL rnd_exclusive n=%0d got=%b exp=at most one", n, outs[3:1]); end
      end
      @(posedge clk);
      if (rst) begin
        m_ph = 0; m_pc = 0; m_run = 0; m_stop = 0; m_src = 0;
      end else begin
        case (m_ph)
          0: begin
            if (p) m_run = 0;
            else if (m) begin m_ph = 1; m_src = 0; end
            else if (s) begin m_ph = 2; m_src = 1; m_run = 0; end
            else if (r) begin m_ph = 2; m_src = 1; m_run = 1; end
          end
          1: m_ph = 3;
          2: begin
            if (p) m_stop = 1;
            m_ph = (mem[m_pc][15:12] == 4'hF) ? 4 : 3;
          end
          3: begin
            if (m_src) m_pc = bt ? int'(tgt) : (m_pc + 1) % 256;
            if (m_run && !m_stop && !p) m_ph = 2;
            else begin m_ph = 0; m_run = 0; m_stop = 0; end
          end
          default: ;
        endcase
      end
      #1;
    end
    tick(1, 0, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; manual_req = 1'b0; step_req = 1'b0; run_req = 1'b0; stop_req = 1'b0;
    branch_taken = 1'b0; branch_target = 8'h00;
    fill_mem(16'h1000);
    @(posedge clk);
    #1;
    test_reset;
    test_manual;
    test_step;
    test_ignored;
    test_run_halt;
    test_wrap_branch_stop;
    test_stop_in_idle;
    test_reset_exec;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_controller.md
EXEC_CONTROLLER -- requirements
Module: exec_controller

Interface
REQ-001 Parameter PC_W, default 8, instruction-memory address width.
REQ-002 Parameter HALT_OPC, default 4'hF, opcode value in instr[15:12] that halts the processor.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 manual_req  input  1  one-cycle pulse: execute the instruction on the Basys switches.
REQ-006 step_req  input  1  one-cycle pulse: execute one instruction from memory.
REQ-007 run_req  input  1  one-cycle pulse: free-run from memory.
REQ-008 stop_req  input  1  one-cycle pulse: leave free-run after the current instruction.
REQ-009 imem_data  input  16  instruction at address pc, combinational read.
REQ-010 branch_taken  input  1  datapath branch decision, sampled only in EXEC.
REQ-011 branch_target  input  PC_W  next pc when branch_taken.
REQ-012 sel_basys  output  1  load strobe: instruction register takes the switch instruction.
REQ-013 sel_mem  output  1  load strobe: instruction register takes imem_data.
REQ-014 exec_en  output  1  one-cycle commit strobe for register-file and memory writes.
REQ-015 pc  output  PC_W  current instruction address, driven to instruction memory.
REQ-016 halted  output  1  high while in HALT.
REQ-017 state_dbg  output  3  current state encoding, for the seven-segment display.

Function
REQ-018 FSM states: IDLE, LOAD_MAN, LOAD_MEM, EXEC, HALT.
REQ-019 IDLE: request priority is stop_req > manual_req > step_req > run_req; stop_req in IDLE keeps IDLE and clears run_mode.
REQ-020 IDLE + manual_req -> LOAD_MAN, from_mem=0; step_req -> LOAD_MEM, from_mem=1, run_mode=0; run_req -> LOAD_MEM, from_mem=1, run_mode=1.
REQ-021 Requests other than stop_req are ignored outside IDLE; they are not queued.
REQ-022 LOAD_MAN: sel_basys=1 for exactly that cycle; next state EXEC.
REQ-023 LOAD_MEM, imem_data[15:12]!=HALT_OPC: sel_mem=1 for that cycle; next state EXEC.
REQ-024 LOAD_MEM, imem_data[15:12]==HALT_OPC: sel_mem=0, no exec_en; next state HALT; pc unchanged.
REQ-025 EXEC: exec_en=1 for exactly one cycle; sel_basys=sel_mem=0.
REQ-026 EXEC with from_mem=1: pc <= branch_taken ? branch_target : pc+1, modulo 2^PC_W (2^PC_W-1 wraps to 0).
REQ-027 EXEC with from_mem=0: pc unchanged; branch_taken ignored.
REQ-028 EXEC exit: run_mode=1 and stop_pending=0 -> LOAD_MEM; otherwise -> IDLE, clearing run_mode and stop_pending.
REQ-029 stop_req in LOAD_MEM or EXEC sets stop_pending; stop_req in the same EXEC cycle that exits also stops the run.
REQ-030 HALT: halted=1; all requests ignored; only reset exits.
REQ-031 sel_basys, sel_mem and exec_en are mutually exclusive in every cycle.
REQ-032 Latency: request pulse to exec_en is exactly 2 cycles. Free-run throughput is one instruction per 2 cycles.

Reset
REQ-033 With reset high at a clock edge, the next state is IDLE and pc=0. run_mode, stop_pending, from_mem, sel_basys, sel_mem, exec_en and halted all go to 0. state_dbg shows the IDLE encoding.
REQ-034 Reset overrides every other input in every state, including mid-EXEC. No exec_en is asserted in the cycle after reset.

Structure
REQ-035 Package exec_ctrl_pkg holds the state enum (3-bit), HALT_OPC default, and the opcode field position constants (15:12).
REQ-036 One sub-module, pc_counter, implements pc: reset, hold, increment with wrap, and branch load.
REQ-037 All outputs except the Mealy halt suppression of sel_mem (REQ-024) are decoded from registered state.

Verification
REQ-038 manual_req at cycle 0 -> sel_basys=1 at cycle 1, exec_en=1 at cycle 2, IDLE at cycle 3, pc stays 0.
REQ-039 step_req with pc=5 and imem_data=16'h1234, branch_taken=0 -> sel_mem at cycle 1, exec_en at cycle 2, pc=6 at cycle 3, then IDLE.
REQ-040 run_req with memory holding 3 non-halt words, then 16'hF000 at address 3 -> exec_en pulses at cycles 2, 4 and 6. pc=3 at cycle 7, sel_mem=0, halted=1 from cycle 8 and held; later manual_req is ignored.
REQ-041 Free-run with pc=8'hFF, branch_taken=0 -> pc wraps to 0. Branch with branch_target=8'h10 in EXEC -> pc=8'h10 next cycle.
REQ-042 stop_req during a free-run EXEC -> that instruction commits and the FSM returns to IDLE. stop_req together with run_req in IDLE -> stays IDLE, no sel_mem.
REQ-043 reset asserted in EXEC -> no exec_en next cycle, IDLE, pc=0, halted=0. Reset in HALT -> IDLE with halted=0.
